// File: rtl/auth_checker.sv
// auth_checker: login responder for the game controller.
// Collects a 4-digit BCD user ID and a 4-digit password, one digit per rising
// edge of the load enables, looks the ID up in a parameterised user table and
// reports the result through flags consumed by the controller's state machine.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   enableSetUserIDFlag       level; rising edge loads one ID digit
//   enableSetPassFlag         level; rising edge loads one password digit
//   digitIn[3:0]              digit from the switches
//   userIDfoundFlag           level: ID matched a table slot
//   accessFlag                level: password correct
//   blinkFlag                 1-cycle pulse: wrong password, tries remain
//   outOfAttemptsFlag         level: locked out
//   idErrorFlag               1-cycle pulse: ID not in table
//   userID_digit1..4          entered ID (digit1 = most recent entry)
//   userIndex[1:0]            matched slot (whoIsPlaying)
//   attemptsLeft[1:0]         remaining password tries
module auth_checker #(
  parameter int          NUM_USERS    = 4,
  parameter int          MAX_ATTEMPTS = 3,
  parameter logic [63:0] USER_IDS     = 64'h4444_3333_2222_1111,
  parameter logic [63:0] USER_PASS    = 64'h8888_7777_6666_5555
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enableSetUserIDFlag,
  input  logic       enableSetPassFlag,
  input  logic [3:0] digitIn,
  output logic       userIDfoundFlag,
  output logic       accessFlag,
  output logic       blinkFlag,
  output logic       outOfAttemptsFlag,
  output logic       idErrorFlag,
  output logic [3:0] userID_digit1,
  output logic [3:0] userID_digit2,
  output logic [3:0] userID_digit3,
  output logic [3:0] userID_digit4,
  output logic [1:0] userIndex,
  output logic [1:0] attemptsLeft
);

  typedef enum logic [2:0] {
    S_GET_ID   = 3'd0,
    S_LOOKUP   = 3'd1,
    S_GET_PASS = 3'd2,
    S_CHECK    = 3'd3,
    S_GRANTED  = 3'd4,
    S_LOCKED   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        id_prev_q, pass_prev_q;
  logic [15:0] id_dig_q, id_dig_d;     // {digit4, digit3, digit2, digit1}
  logic [15:0] pass_q, pass_d;
  logic [1:0]  id_cnt_q, id_cnt_d;
  logic [1:0]  pass_cnt_q, pass_cnt_d;
  logic        found_q, found_d;
  logic        access_q, access_d;
  logic        blink_q, blink_d;
  logic        lock_q, lock_d;
  logic        iderr_q, iderr_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  att_q, att_d;

  logic        id_stb_s, pass_stb_s;
  logic        hit_s;
  logic [1:0]  hit_idx_s;
  logic [15:0] pass_exp_s;

  assign id_stb_s   = enableSetUserIDFlag & ~id_prev_q;
  assign pass_stb_s = enableSetPassFlag & ~pass_prev_q;

  // Table search; scanning downward lets the lowest matching slot win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = 2'd0;
    for (int k = NUM_USERS - 1; k >= 0; k--) begin
      if (id_dig_q == USER_IDS[16*k +: 16]) begin
        hit_s     = 1'b1;
        hit_idx_s = 2'(k);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  assign pass_exp_s = USER_PASS[{idx_q, 4'b0000} +: 16];

  // Next-state and next-output logic for the login sequence.
  always_comb begin
    state_d    = state_q;
    id_dig_d   = id_dig_q;
    pass_d     = pass_q;
    id_cnt_d   = id_cnt_q;
    pass_cnt_d = pass_cnt_q;
    found_d    = found_q;
    access_d   = access_q;
    lock_d     = lock_q;
    blink_d    = 1'b0;
    iderr_d    = 1'b0;
    idx_d      = idx_q;
    att_d      = att_q;
    case (state_q)
      S_GET_ID: begin
        if (id_stb_s) begin
          id_dig_d = {id_dig_q[11:0], digitIn};
          if (id_cnt_q == 2'd3) begin
            id_cnt_d = 2'd0;
            state_d  = S_LOOKUP;
          end else begin
            id_cnt_d = id_cnt_q + 2'd1;
          end
        end else begin
          id_dig_d = id_dig_q;
        end
      end
      S_LOOKUP: begin
        if (hit_s) begin
          found_d = 1'b1;
          idx_d   = hit_idx_s;
          state_d = S_GET_PASS;
        end else begin
          iderr_d  = 1'b1;
          id_dig_d = 16'h0000;
          state_d  = S_GET_ID;
        end
      end
      S_GET_PASS: begin
        if (pass_stb_s) begin
          pass_d = {pass_q[11:0], digitIn};
          if (pass_cnt_q == 2'd3) begin
            pass_cnt_d = 2'd0;
            state_d    = S_CHECK;
          end else begin
            pass_cnt_d = pass_cnt_q + 2'd1;
          end
        end else begin
          pass_d = pass_q;
        end
      end
      S_CHECK: begin
        if (pass_q == pass_exp_s) begin
          access_d = 1'b1;
          state_d  = S_GRANTED;
        end else if (att_q > 2'd1) begin
          att_d   = att_q - 2'd1;
          blink_d = 1'b1;
          pass_d  = 16'h0000;
          state_d = S_GET_PASS;
        end else begin
          // Final try used up: lock out without a blink pulse.
          att_d   = 2'd0;
          lock_d  = 1'b1;
          state_d = S_LOCKED;
        end
      end
      S_GRANTED: state_d = S_GRANTED;
      S_LOCKED:  state_d = S_LOCKED;
      default:   state_d = S_GET_ID;
    endcase
  end

  // State and output registers; edge-detect history updates in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_GET_ID;
      id_prev_q   <= 1'b0;
      pass_prev_q <= 1'b0;
      id_dig_q    <= 16'h0000;
      pass_q      <= 16'h0000;
      id_cnt_q    <= 2'd0;
      pass_cnt_q  <= 2'd0;
      found_q     <= 1'b0;
      access_q    <= 1'b0;
      blink_q     <= 1'b0;
      lock_q      <= 1'b0;
      iderr_q     <= 1'b0;
      idx_q       <= 2'd0;
      att_q       <= 2'(MAX_ATTEMPTS);
    end else begin
      state_q     <= state_d;
      id_prev_q   <= enableSetUserIDFlag;
      pass_prev_q <= enableSetPassFlag;
      id_dig_q    <= id_dig_d;
      pass_q      <= pass_d;
      id_cnt_q    <= id_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      found_q     <= found_d;
      access_q    <= access_d;
      blink_q     <= blink_d;
      lock_q      <= lock_d;
      iderr_q     <= iderr_d;
      idx_q       <= idx_d;
      att_q       <= att_d;
    end
  end

  assign userIDfoundFlag   = found_q;
  assign accessFlag        = access_q;
  assign blinkFlag         = blink_q;
  assign outOfAttemptsFlag = lock_q;
  assign idErrorFlag       = iderr_q;
  assign userID_digit1     = id_dig_q[3:0];
  assign userID_digit2     = id_dig_q[7:4];
  assign userID_digit3     = id_dig_q[11:8];
  assign userID_digit4     = id_dig_q[15:12];
  assign userIndex         = idx_q;
  assign attemptsLeft      = att_q;

endmodule

// File: tb/tb_auth_checker.sv
// Scoreboard bench for auth_checker: stimulus pushes expected flag events
// (kind, cycle, index, attempts, displayed digits); a monitor pops and
// compares each event the DUT raises. Direct checks cover reset/hold states.
module tb_auth_checker;

  localparam int K_FOUND = 0, K_IDERR = 1, K_BLINK = 2, K_ACCESS = 3, K_LOCK = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [1:0]  idx;
    logic [1:0]  att;
    logic [15:0] dig;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_id = 1'b0;
  logic       en_pass = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       found, access, blink, lock, iderr;
  logic [3:0] d1, d2, d3, d4;
  logic [1:0] uidx, att;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_edge = 0;
  logic found_p = 1'b0, access_p = 1'b0, lock_p = 1'b0;

  auth_checker dut (
    .clk(clk), .rst(rst),
    .enableSetUserIDFlag(en_id), .enableSetPassFlag(en_pass), .digitIn(digit_in),
    .userIDfoundFlag(found), .accessFlag(access), .blinkFlag(blink),
    .outOfAttemptsFlag(lock), .idErrorFlag(iderr),
    .userID_digit1(d1), .userID_digit2(d2), .userID_digit3(d3), .userID_digit4(d4),
    .userIndex(uidx), .attemptsLeft(att)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " found"}, int'(found), 0);
    chk({tag, " access"}, int'(access), 0);
    chk({tag, " blink"}, int'(blink), 0);
    chk({tag, " lock"}, int'(lock), 0);
    chk({tag, " iderr"}, int'(iderr), 0);
    chk({tag, " digits"}, int'({d4, d3, d2, d1}), 0);
    chk({tag, " userIndex"}, int'(uidx), 0);
    chk({tag, " attemptsLeft"}, int'(att), 3);
  endtask

  task automatic press_id(input logic [3:0] d);
    @(negedge clk); digit_in = d; en_id = 1'b1;
    @(negedge clk); en_id = 1'b0; last_edge = cyc;
  endtask

  task automatic press_pass(input logic [3:0] d);
    @(negedge clk); digit_in = d; en_pass = 1'b1;
    @(negedge clk); en_pass = 1'b0; last_edge = cyc;
  endtask

  task automatic enter_id(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press_id(v[4*i +: 4]);
  endtask

  task automatic enter_pass(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press_pass(v[4*i +: 4]);
  endtask

  // Expected event visible one edge after the edge that took the 4th digit.
  task automatic expect_ev(input int kind, input logic [1:0] idx,
                           input logic [1:0] a, input logic [15:0] dig);
    ev_t e;
    e.kind = kind; e.cyc = last_edge + 1; e.idx = idx; e.att = a; e.dig = dig;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic on_event(input int kind);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx !== uidx || e.att !== att ||
          e.dig !== {d4, d3, d2, d1}) begin
        n_err++;
        $display("FAIL event: got kind=%0d cyc=%0d idx=%0d att=%0d dig=%h, expected kind=%0d cyc=%0d idx=%0d att=%0d dig=%h",
                 kind, cyc, uidx, att, {d4, d3, d2, d1}, e.kind, e.cyc, e.idx, e.att, e.dig);
      end
    end
  endtask

  // Monitor: turn flag rises and pulses into events and score them.
  always @(negedge clk) begin
    if (rst) begin
      if (found && !found_p)   on_event(K_FOUND);
      if (iderr)               on_event(K_IDERR);
      if (blink)               on_event(K_BLINK);
      if (access && !access_p) on_event(K_ACCESS);
      if (lock && !lock_p)     on_event(K_LOCK);
    end
    found_p  <= found;
    access_p <= access;
    lock_p   <= lock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;

    // Known user 1, correct password first time.
    enter_id(16'h2222);
    expect_ev(K_FOUND, 2'd1, 2'd3, 16'h2222);
    enter_pass(16'h6666);
    expect_ev(K_ACCESS, 2'd1, 2'd3, 16'h2222);
    repeat (3) @(negedge clk);
    press_id(4'd9);
    press_pass(4'd9);
    repeat (4) @(negedge clk);
    chk("granted digits", int'({d4, d3, d2, d1}), 16'h2222);
    chk("granted access", int'(access), 1);
    chk("granted attempts", int'(att), 3);
    chk("granted lock", int'(lock), 0);

    // Unknown ID, then user 0 with two wrong passwords then correct.
    do_reset();
    press_pass(4'd7);
    enter_id(16'h1234);
    expect_ev(K_IDERR, 2'd0, 2'd3, 16'h0000);
    repeat (2) @(negedge clk);
    enter_id(16'h1111);
    expect_ev(K_FOUND, 2'd0, 2'd3, 16'h1111);
    enter_pass(16'h0000);
    expect_ev(K_BLINK, 2'd0, 2'd2, 16'h1111);
    repeat (2) @(negedge clk);
    enter_pass(16'h0000);
    expect_ev(K_BLINK, 2'd0, 2'd1, 16'h1111);
    repeat (2) @(negedge clk);
    enter_pass(16'h5555);
    expect_ev(K_ACCESS, 2'd0, 2'd1, 16'h1111);
    repeat (3) @(negedge clk);

    // Lockout after three wrong passwords; correct one afterwards ignored.
    do_reset();
    enter_id(16'h1111);
    expect_ev(K_FOUND, 2'd0, 2'd3, 16'h1111);
    for (int t = 0; t < 3; t++) begin
      enter_pass(16'h0120);
      if (t < 2) expect_ev(K_BLINK, 2'd0, 2'(2 - t), 16'h1111);
      else       expect_ev(K_LOCK, 2'd0, 2'd0, 16'h1111);
      repeat (2) @(negedge clk);
    end
    enter_pass(16'h5555);
    repeat (4) @(negedge clk);
    chk("locked access", int'(access), 0);
    chk("locked lock", int'(lock), 1);
    chk("locked attempts", int'(att), 0);

    // Held enable loads one digit only; reset mid-password discards input.
    do_reset();
    @(negedge clk); digit_in = 4'd3; en_id = 1'b1;
    repeat (50) @(negedge clk);
    en_id = 1'b0;
    chk("held digit1", int'(d1), 3);
    chk("held digit2", int'(d2), 0);
    chk("held found", int'(found), 0);
    for (int i = 0; i < 3; i++) press_id(4'd3);
    expect_ev(K_FOUND, 2'd2, 2'd3, 16'h3333);
    repeat (2) @(negedge clk);
    press_pass(4'd7);
    press_pass(4'd7);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async reset");
    @(negedge clk); rst = 1'b1;
    enter_id(16'h4444);
    expect_ev(K_FOUND, 2'd3, 2'd3, 16'h4444);
    enter_pass(16'h8888);
    expect_ev(K_ACCESS, 2'd3, 2'd3, 16'h4444);

    repeat (8) @(negedge clk);
    chk("pending events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
